// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared QS2.13 constants, saturation helper and LIF FSM states
package snn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_BITS  = 13;
  localparam int WIDE_WIDTH         = DEFAULT_DATA_WIDTH + 4;

  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] MAX_VAL = 16'sh7FFF;
  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] MIN_VAL = 16'sh8000;

  typedef enum logic [1:0] {
    LIF_IDLE,
    LIF_RECEIVING,
    LIF_DONE
  } lif_state_t;

  function automatic logic signed [DEFAULT_DATA_WIDTH-1:0] saturate(
    input logic signed [WIDE_WIDTH-1:0] x
  );
    logic signed [WIDE_WIDTH-1:0] w_max;
    logic signed [WIDE_WIDTH-1:0] w_min;
    w_max = WIDE_WIDTH'(MAX_VAL);
    w_min = WIDE_WIDTH'(MIN_VAL);
    if (x > w_max) begin
      return MAX_VAL;
    end else if (x < w_min) begin
      return MIN_VAL;
    end else begin
      return x[DEFAULT_DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// rtl/lif_neuron_update.sv - combinational decay, integrate, fire and subtract-reset for one neuron
module lif_neuron_update
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] i_m,
  input  logic signed [DATA_WIDTH-1:0] i_current,
  input  logic signed [DATA_WIDTH-1:0] i_beta,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  output logic signed [DATA_WIDTH-1:0] o_next_m,
  output logic                         o_fire
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = DATA_WIDTH + 4;

  logic signed [PROD_W-1:0]     w_product;
  logic signed [PROD_W-1:0]     w_decayed;
  logic signed [SUM_W-1:0]      w_sum;
  logic signed [DATA_WIDTH-1:0] w_v;

  assign w_product = PROD_W'(i_beta) * PROD_W'(i_m);
  // Arithmetic shift floors toward -inf; with BETA <= 1.0 the result fits DATA_WIDTH.
  assign w_decayed = w_product >>> FRAC_BITS;
  assign w_sum     = $signed(w_decayed[SUM_W-1:0]) + SUM_W'(i_current);
  assign w_v       = saturate(w_sum);

  assign o_fire   = (w_v >= i_threshold);
  assign o_next_m = o_fire ? (w_v - i_threshold) : w_v;

endmodule

// File: rtl/lif_layer.sv
// rtl/lif_layer.sv - serial LIF layer: per-current membrane update, timestep FSM, sequence checker
module lif_layer
  import snn_pkg::*;
#(
  parameter int                    NUM_NEURONS = 16,
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    FRAC_BITS   = DEFAULT_FRAC_BITS,
  parameter logic signed [DATA_WIDTH-1:0] BETA      = 16'sh1CCD,
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = 16'sh2000,
  localparam int                   IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] current_in,
  input  logic        [IDX_W-1:0]      current_idx,
  input  logic                         current_valid,
  input  logic                         current_done,
  input  logic                         clear_state,
  output logic        [NUM_NEURONS-1:0] spikes,
  output logic signed [DATA_WIDTH-1:0] membranes [0:NUM_NEURONS-1],
  output logic                         step_done,
  output logic                         seq_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  lif_state_t                   r_state;
  logic signed [DATA_WIDTH-1:0] r_mem [0:NUM_NEURONS-1];
  logic [NUM_NEURONS-1:0]       r_spikes;
  logic [IDX_W:0]               r_expected_idx;
  logic                         r_step_done;
  logic                         r_seq_error;

  logic signed [DATA_WIDTH-1:0] w_next_m;
  logic                         w_fire;
  logic [IDX_W:0]               w_exp;
  logic                         w_bad;

  lif_neuron_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_update (
    .i_m         (r_mem[current_idx]),
    .i_current   (current_in),
    .i_beta      (BETA),
    .i_threshold (THRESHOLD),
    .o_next_m    (w_next_m),
    .o_fire      (w_fire)
  );

  // Any current arriving outside RECEIVING opens a new timestep, so it must be index 0.
  // The counter is one bit wider than the index so a 17th current is also flagged.
  assign w_exp = (r_state == LIF_RECEIVING) ? r_expected_idx : '0;
  assign w_bad = ({1'b0, current_idx} != w_exp) || (current_done && (current_idx != LAST_IDX));

  always_ff @(posedge clk) begin
    if (reset || clear_state) begin
      r_state        <= LIF_IDLE;
      r_spikes       <= '0;
      r_expected_idx <= '0;
      r_step_done    <= 1'b0;
      r_seq_error    <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_step_done <= current_valid && current_done;
      if (current_valid) begin
        r_mem[current_idx]    <= w_next_m;
        r_spikes[current_idx] <= w_fire;
        r_expected_idx        <= w_exp + 1'b1;
        if (w_bad) begin
          r_seq_error <= 1'b1;
        end
        r_state <= current_done ? LIF_DONE : LIF_RECEIVING;
      end else if (r_state == LIF_DONE) begin
        r_state <= LIF_IDLE;
      end
    end
  end

  assign spikes    = r_spikes;
  assign membranes = r_mem;
  assign step_done = r_step_done;
  assign seq_error = r_seq_error;

endmodule

// File: tb/tb_lif_layer.sv
// tb/tb_lif_layer.sv - randomized and directed bench for lif_layer against a behavioural model
module tb_lif_layer;

  localparam int N    = 16;
  localparam int BETA = 7373;
  localparam int THR  = 8192;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] current_in = '0;
  logic        [3:0]  current_idx = '0;
  logic               current_valid = 1'b0;
  logic               current_done = 1'b0;
  logic               clear_state = 1'b0;
  logic [N-1:0]       spikes;
  logic signed [15:0] membranes [0:N-1];
  logic               step_done;
  logic               seq_error;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  bit chk_en = 1'b0;

  int m_mem [N];
  bit m_spk [N];
  bit m_done;
  bit m_err;
  int m_count;
  bit m_in_step;

  lif_layer dut (
    .clk           (clk),
    .reset         (reset),
    .current_in    (current_in),
    .current_idx   (current_idx),
    .current_valid (current_valid),
    .current_done  (current_done),
    .clear_state   (clear_state),
    .spikes        (spikes),
    .membranes     (membranes),
    .step_done     (step_done),
    .seq_error     (seq_error)
  );

  always #5 clk = ~clk;

  function automatic int lif_next(input int m, input int cur, output bit f);
    longint prod;
    int v;
    prod = longint'(BETA) * longint'(m);
    v = int'(prod >>> 13) + cur;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    f = (v >= THR);
    return f ? v - THR : v;
  endfunction

  always @(posedge clk) begin
    if (reset || clear_state) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] = 0;
        m_spk[i] = 1'b0;
      end
      m_done = 1'b0;
      m_err = 1'b0;
      m_count = 0;
      m_in_step = 1'b0;
    end else begin
      m_done = current_valid && current_done;
      if (current_valid) begin
        bit f;
        int n;
        n = int'(current_idx);
        if (!m_in_step) m_count = 0;
        if (n != m_count || (current_done && n != N - 1)) m_err = 1'b1;
        m_mem[n] = lif_next(m_mem[n], int'(current_in), f);
        m_spk[n] = f;
        m_count++;
        m_in_step = !current_done;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (int'(membranes[i]) != m_mem[i]) begin
          failures++;
          $display("FAIL membrane[%0d] t=%0t actual=%0d required=%0d", i, $time, membranes[i], m_mem[i]);
        end
        checks++;
        if (spikes[i] !== m_spk[i]) begin
          failures++;
          $display("FAIL spike[%0d] t=%0t actual=%b required=%b", i, $time, spikes[i], m_spk[i]);
        end
      end
      checks++;
      if (step_done !== m_done) begin
        failures++;
        $display("FAIL step_done t=%0t actual=%b required=%b", $time, step_done, m_done);
      end
      checks++;
      if (seq_error !== m_err) begin
        failures++;
        $display("FAIL seq_error t=%0t actual=%b required=%b", $time, seq_error, m_err);
      end
      if (step_done === 1'b1) done_pulses++;
    end
  end

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic lit_all_mem(input string name, input int req);
    for (int i = 0; i < N; i++) lit(name, int'(membranes[i]), req);
  endtask

  task automatic beat(input bit v, input int idx, input int cur, input bit d, input bit clr);
    @(negedge clk);
    current_valid = v;
    current_idx   = idx[3:0];
    current_in    = cur[15:0];
    current_done  = d;
    clear_state   = clr;
  endtask

  task automatic idle();
    beat(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    beat(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic full_step(input int cur);
    for (int i = 0; i < N; i++) beat(1'b1, i, cur, i == N - 1, 1'b0);
  endtask

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    idle();
    lit("reset_spikes", int'(spikes), 0);
    lit_all_mem("reset_mem", 0);
    lit("reset_step_done", int'(step_done), 0);

    p0 = done_pulses;
    full_step(16'h1000); idle();
    lit_all_mem("step1_mem", 4096);
    lit("step1_spikes", int'(spikes), 0);
    lit("step1_done", int'(step_done), 1);
    full_step(16'h1000); idle();
    lit_all_mem("step2_mem", 7782);
    lit("step2_spikes", int'(spikes), 0);
    full_step(16'h1000); idle(); idle();
    lit_all_mem("step3_mem", 2907);
    lit("step3_spikes", int'(spikes), 16'hFFFF);
    lit("three_done_pulses", done_pulses - p0, 3);

    clear();
    beat(1'b1, 0, 16'h7FFF, 1'b0, 1'b0); idle();
    lit("max_cur_mem", int'(membranes[0]), 24575);
    lit("max_cur_spike", int'(spikes[0]), 1);
    clear();
    for (int k = 0; k < 4; k++) beat(1'b1, k, -32768, 1'b0, 1'b0);
    idle();
    clear();
    for (int k = 0; k < 3; k++) begin
      beat(1'b1, 0, -32768, 1'b1, 1'b0);
      beat(1'b1, 1, -32768, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) beat(1'b1, k + 2, -32768, 1'b0, 1'b0);
    idle();
    lit("neg_sat_mem", int'(membranes[0]), -32768);
    lit("neg_sat_spike", int'(spikes[0]), 0);

    clear();
    p0 = done_pulses;
    for (int i = 0; i < 8; i++) beat(1'b1, i, 16'h1000, 1'b0, 1'b0);
    beat(1'b1, 8, 16'h1000, 1'b0, 1'b1);
    idle(); idle();
    lit_all_mem("abort_mem", 0);
    lit("abort_no_done", done_pulses - p0, 0);
    full_step(16'h1000); idle();
    lit_all_mem("after_abort_mem", 4096);

    clear();
    beat(1'b1, 0, 100, 1'b0, 1'b0);
    beat(1'b1, 1, 100, 1'b0, 1'b0);
    beat(1'b1, 3, 100, 1'b0, 1'b0);
    idle();
    lit("seq_skip", int'(seq_error), 1);
    for (int i = 4; i < N; i++) beat(1'b1, i, 100, i == N - 1, 1'b0);
    idle();
    lit("seq_held", int'(seq_error), 1);
    clear(); idle();
    lit("seq_cleared", int'(seq_error), 0);
    for (int i = 0; i < N - 1; i++) beat(1'b1, i, 0, i == N - 2, 1'b0);
    idle();
    lit("seq_early_done", int'(seq_error), 1);
    clear();

    p0 = done_pulses;
    full_step(16'h1000);
    full_step(16'h1000);
    idle();
    lit_all_mem("b2b_mem", 7782);
    lit("b2b_seq_ok", int'(seq_error), 0);
    idle();
    lit("b2b_done_pulses", done_pulses - p0, 2);

    for (int i = 0; i < 5; i++) beat(1'b1, i, 16'h1000, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1; current_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    lit_all_mem("reset_mid_mem", 0);
    lit("reset_mid_spikes", int'(spikes), 0);
    full_step(16'h1000); idle();
    lit_all_mem("post_reset_mem", 4096);

    for (int s = 0; s < 60; s++) begin
      bit aborted;
      aborted = 1'b0;
      for (int i = 0; i < N && !aborted; i++) begin
        int idx;
        int cur;
        idx = i;
        if ($urandom_range(0, 99) < 3) idx = $urandom_range(0, N - 1);
        if ($urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 65535)) - 32768;
        else cur = int'($urandom_range(0, 6000)) - 2000;
        if ($urandom_range(0, 99) < 2) begin
          beat(1'b1, idx, cur, 1'b0, 1'b1);
          aborted = 1'b1;
        end else begin
          beat(1'b1, idx, cur, i == N - 1, 1'b0);
        end
        if ($urandom_range(0, 9) == 0) beat(1'b0, 0, 0, $urandom_range(0, 1) == 1, 1'b0);
      end
      repeat ($urandom_range(0, 2)) beat(1'b0, 0, 0, $urandom_range(0, 1) == 1, 1'b0);
      if ($urandom_range(0, 9) == 0) clear();
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
